// File: rtl/line_buffer_nrow.sv
// N-row line buffer: one word in per beat, LINES vertically aligned taps out.
// Frame-sync FSM, tlast-checked line length and selectable top-border handling.
module line_buffer_nrow #(
   parameter int unsigned DATA_W      = 33,
   parameter int unsigned LINES       = 3,
   parameter int unsigned LINE_WORDS  = 480,
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned BORDER_MODE = 0
) (
   input  logic                     I_clk,
   input  logic                     I_rst_n,
   input  logic                     I_tuser,
   input  logic                     I_tlast,
   input  logic                     I_valid,
   input  logic [DATA_W-1:0]        I_data,
   output logic                     O_valid,
   output logic [LINES*DATA_W-1:0]  O_data,
   output logic                     O_tuser,
   output logic                     O_tlast,
   output logic                     O_len_err
);

   localparam int unsigned NRAM = LINES - 1;
   localparam int unsigned RW   = $clog2(LINES);
   localparam int unsigned RAW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(LINE_WORDS - 1);
   localparam logic [RW-1:0]     LAST_R = RW'(LINES - 1);

   typedef enum logic [1:0] {WAIT_SOF, PRIME, RUN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   wcnt;
   logic [RW-1:0]       rcnt;
   logic                pend;

   logic                sof_c, acc_c, at_end_c, wrap_c, lerr_c, emit_c, pend_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [RW-1:0]       row_c, rn_c;

   // Stage 1: registered input aligned with RAM read data
   logic                v1, emit1, tu1, wrap1, le1;
   logic [DATA_W-1:0]   d1;
   logic [ADDR_W-1:0]   a1;
   logic [RW-1:0]       r1;
   logic [DATA_W-1:0]   rd      [NRAM];
   logic [DATA_W-1:0]   wdata_c [NRAM];
   logic [DATA_W-1:0]   tap_c   [LINES];
   logic [LINES*DATA_W-1:0] out_c;

   logic [DATA_W-1:0]   ram [NRAM][LINE_WORDS];

   // Beat decode: an SOF beat restarts the frame at word 0 of row 0
   always_comb begin
      sof_c    = I_valid & I_tuser;
      acc_c    = I_valid & (sof_c | (state != WAIT_SOF));
      addr_c   = sof_c ? '0 : wcnt;
      row_c    = sof_c ? '0 : rcnt;
      at_end_c = (addr_c == LAST_W);
      wrap_c   = I_tlast | at_end_c;
      lerr_c   = I_tlast ^ at_end_c;
      rn_c     = (wrap_c && (row_c != LAST_R)) ? row_c + RW'(1) : row_c;
      emit_c   = (BORDER_MODE != 0) ? 1'b1 : ((state == RUN) && !sof_c);
      pend_c   = sof_c | pend;
   end

   // Frame FSM and word/row counters
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state <= WAIT_SOF;
         wcnt  <= '0;
         rcnt  <= '0;
         pend  <= 1'b0;
      end else if (acc_c) begin
         state <= (rn_c == LAST_R) ? RUN : PRIME;
         wcnt  <= wrap_c ? '0 : addr_c + ADDR_W'(1);
         rcnt  <= rn_c;
         pend  <= pend_c & ~emit_c;
      end
   end

   // Cascade write data: RAM0 takes the new word, RAM k the row RAM k-1 held
   always_comb begin
      for (int k = 0; k < int'(NRAM); k++) begin
         wdata_c[k] = (k == 0) ? d1 : rd[(k == 0) ? 0 : k - 1];
      end
   end

   always_ff @(posedge I_clk) begin
      if (v1) begin
         for (int k = 0; k < int'(NRAM); k++) begin
            ram[k][a1[RAW-1:0]] <= wdata_c[k];
         end
      end
   end

   // Read with forwarding when the previous beat writes the same address
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         v1    <= 1'b0;
         d1    <= '0;
         a1    <= '0;
         r1    <= '0;
         emit1 <= 1'b0;
         tu1   <= 1'b0;
         wrap1 <= 1'b0;
         le1   <= 1'b0;
         for (int k = 0; k < int'(NRAM); k++) rd[k] <= '0;
      end else begin
         v1 <= acc_c;
         if (acc_c) begin
            d1    <= I_data;
            a1    <= addr_c;
            r1    <= row_c;
            emit1 <= emit_c;
            tu1   <= pend_c;
            wrap1 <= wrap_c;
            le1   <= lerr_c;
            for (int k = 0; k < int'(NRAM); k++) begin
               if (v1 && (a1 == addr_c)) rd[k] <= wdata_c[k];
               else                      rd[k] <= ram[k][addr_c[RAW-1:0]];
            end
         end
      end
   end

   // Tap select: unfilled rows replicate the oldest valid row in border mode 1
   always_comb begin
      for (int k = 0; k < int'(LINES); k++) begin
         tap_c[k] = (k == 0) ? d1 : rd[(k == 0) ? 0 : k - 1];
      end
      out_c = '0;
      for (int k = 0; k < int'(LINES); k++) begin
         out_c[k*DATA_W +: DATA_W] = tap_c[k];
         if ((BORDER_MODE != 0) && (RW'(k) > r1)) begin
            for (int j = 0; j < int'(LINES); j++) begin
               if (RW'(j) == r1) out_c[k*DATA_W +: DATA_W] = tap_c[j];
            end
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         O_valid   <= 1'b0;
         O_data    <= '0;
         O_tuser   <= 1'b0;
         O_tlast   <= 1'b0;
         O_len_err <= 1'b0;
      end else begin
         O_valid   <= v1 & emit1;
         O_tuser   <= v1 & emit1 & tu1;
         O_tlast   <= v1 & emit1 & wrap1;
         O_len_err <= v1 & le1;
         if (v1 && emit1) O_data <= out_c;
      end
   end

endmodule

// File: tb/tb_line_buffer_nrow.sv
// Scoreboard bench for line_buffer_nrow: both border modes driven from one stream.
module tb_line_buffer_nrow;

   localparam int unsigned DW = 33;
   localparam int unsigned L  = 3;
   localparam int unsigned LW = 4;
   localparam int unsigned AW = 11;
   localparam int unsigned OW = L * DW;

   logic          clk = 1'b0;
   logic          rst_n, tuser, tlast, valid;
   logic [DW-1:0] data;
   logic          o_valid0, o_tuser0, o_tlast0, o_len_err0;
   logic          o_valid1, o_tuser1, o_tlast1, o_len_err1;
   logic [OW-1:0] o_data0, o_data1;

   line_buffer_nrow #(.DATA_W(DW), .LINES(L), .LINE_WORDS(LW), .ADDR_W(AW), .BORDER_MODE(0)) dut0 (
      .I_clk(clk), .I_rst_n(rst_n), .I_tuser(tuser), .I_tlast(tlast), .I_valid(valid),
      .I_data(data), .O_valid(o_valid0), .O_data(o_data0), .O_tuser(o_tuser0),
      .O_tlast(o_tlast0), .O_len_err(o_len_err0));

   line_buffer_nrow #(.DATA_W(DW), .LINES(L), .LINE_WORDS(LW), .ADDR_W(AW), .BORDER_MODE(1)) dut1 (
      .I_clk(clk), .I_rst_n(rst_n), .I_tuser(tuser), .I_tlast(tlast), .I_valid(valid),
      .I_data(data), .O_valid(o_valid1), .O_data(o_data1), .O_tuser(o_tuser1),
      .O_tlast(o_tlast1), .O_len_err(o_len_err1));

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   due;
      logic          v;
      logic          tu;
      logic          tl;
      logic          le;
      logic [OW-1:0] d;
   } exp_t;

   exp_t          q0[$], q1[$];
   logic [OW-1:0] log0[$], log1[$];
   int            passed = 0, failed = 0, total = 0;

   // Reference: per-column history of the words written at that address
   logic [DW-1:0] col [LW][L-1];
   int unsigned   m_w, m_r;
   bit            m_on, pend0, pend1;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic cmp_out(input string tag, input exp_t e, input logic v, input logic tu,
                          input logic tl, input logic le, input logic [OW-1:0] d);
      chk({tag, "_ctl{v,tuser,tlast,len_err}"}, OW'({v, tu, tl, le}), OW'({e.v, e.tu, e.tl, e.le}));
      if (e.v) chk({tag, "_data"}, d, e.d);
   endtask

   always @(negedge clk) begin
      exp_t e0, e1;
      e0 = '{due: 0, v: 1'b0, tu: 1'b0, tl: 1'b0, le: 1'b0, d: '0};
      e1 = e0;
      if (q0.size() > 0 && q0[0].due == cyc) e0 = q0.pop_front();
      if (q1.size() > 0 && q1[0].due == cyc) e1 = q1.pop_front();
      cmp_out("mode0", e0, o_valid0, o_tuser0, o_tlast0, o_len_err0, o_data0);
      cmp_out("mode1", e1, o_valid1, o_tuser1, o_tlast1, o_len_err1, o_data1);
      if (o_valid0 === 1'b1) log0.push_back(o_data0);
      if (o_valid1 === 1'b1) log1.push_back(o_data1);
   end

   task automatic model(input logic [DW-1:0] d, input logic tu, input logic tl);
      logic [DW-1:0] tap [L];
      logic [OW-1:0] t0, t1;
      int unsigned   a, row, src;
      bit            at_end, wrap, le, emit0;
      if (!tu && !m_on) return;
      if (tu) begin
         m_on = 1; m_w = 0; m_r = 0; pend0 = 1; pend1 = 1;
      end
      a      = m_w;
      row    = m_r;
      at_end = (a == LW - 1);
      wrap   = tl || at_end;
      le     = (tl != at_end);
      tap[0] = d;
      for (int k = 1; k < int'(L); k++) tap[k] = col[a][k-1];
      for (int k = 0; k < int'(L); k++) begin
         src = (k > int'(row)) ? row : k;
         t0[k*DW +: DW] = tap[k];
         t1[k*DW +: DW] = tap[src];
      end
      emit0 = (row == L - 1);
      if (emit0 || le) q0.push_back('{due: cyc + 2, v: emit0, tu: emit0 && pend0,
                                      tl: emit0 && wrap, le: le, d: t0});
      if (emit0) pend0 = 0;
      q1.push_back('{due: cyc + 2, v: 1'b1, tu: pend1, tl: wrap, le: le, d: t1});
      pend1 = 0;
      for (int k = L - 2; k > 0; k--) col[a][k] = col[a][k-1];
      col[a][0] = d;
      m_w = wrap ? 0 : a + 1;
      if (wrap && m_r < L - 1) m_r++;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic tu, input logic tl);
      @(posedge clk); #1;
      valid = 1'b1; data = d; tuser = tu; tlast = tl;
      model(d, tu, tl);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         valid = 1'b0; tuser = 1'b0; tlast = 1'b0;
      end
   endtask

   task automatic frame(input int base, input int rows, input bit gaps);
      for (int r = 0; r < rows; r++) begin
         for (int w = 0; w < int'(LW); w++) begin
            beat(DW'(base + r * 4 + w), (r == 0 && w == 0), (w == int'(LW) - 1));
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
         end
      end
   endtask

   initial begin
      logic [OW-1:0] ev;
      rst_n = 1'b0; valid = 1'b0; tuser = 1'b0; tlast = 1'b0; data = '0;
      m_on = 0; m_w = 0; m_r = 0; pend0 = 0; pend1 = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Words before any SOF are ignored
      beat(DW'(33'h77), 1'b0, 1'b0);
      beat(DW'(33'h78), 1'b0, 1'b1);
      idle(3);

      // Back-to-back frame, directed tap values
      log0.delete(); log1.delete();
      frame(32'h10, 4, 1'b0);
      idle(4);
      chk("mode0_out_count", OW'(log0.size()), OW'(8));
      chk("mode1_out_count", OW'(log1.size()), OW'(16));
      ev = {33'h10, 33'h14, 33'h18};
      if (log0.size() > 0) chk("mode0_row2_w0_taps", log0[0], ev);
      ev = {33'h11, 33'h11, 33'h11};
      if (log1.size() > 1) chk("mode1_row0_w1_taps", log1[1], ev);
      ev = {33'h11, 33'h11, 33'h15};
      if (log1.size() > 5) chk("mode1_row1_w1_taps", log1[5], ev);

      // Same stream with random idle gaps
      log0.delete(); log1.delete();
      frame(32'h10, 4, 1'b1);
      idle(4);
      chk("gap_mode0_out_count", OW'(log0.size()), OW'(8));
      ev = {33'h10, 33'h14, 33'h18};
      if (log0.size() > 0) chk("gap_mode0_row2_w0_taps", log0[0], ev);

      // Short line (tlast at word 2) then long line (no tlast at word 3)
      for (int w = 0; w < 4; w++) beat(DW'(32'h80 + w), (w == 0), (w == 3));
      for (int w = 0; w < 3; w++) beat(DW'(32'h90 + w), 1'b0, (w == 2));
      for (int w = 0; w < 4; w++) beat(DW'(32'hA0 + w), 1'b0, 1'b0);
      for (int w = 0; w < 4; w++) beat(DW'(32'hB0 + w), 1'b0, (w == 3));
      idle(4);

      // SOF in the middle of row 3 restarts priming
      for (int r = 0; r < 3; r++)
         for (int w = 0; w < 4; w++) beat(DW'(32'hC0 + r * 4 + w), (r == 0 && w == 0), (w == 3));
      beat(DW'(33'hCC), 1'b0, 1'b0);
      beat(DW'(33'hCD), 1'b0, 1'b0);
      frame(32'hE0, 3, 1'b0);
      idle(4);

      // Reset mid-row, then words without SOF are ignored
      beat(DW'(33'h150), 1'b1, 1'b0);
      beat(DW'(33'h151), 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0; valid = 1'b0; tuser = 1'b0; tlast = 1'b0;
      q0.delete(); q1.delete();
      m_on = 0; m_w = 0; m_r = 0; pend0 = 0; pend1 = 0;
      #2;
      chk("reset_async_outputs", OW'({o_valid0, o_tuser0, o_tlast0, o_len_err0,
                                      o_valid1, o_tuser1, o_tlast1, o_len_err1}), OW'(0));
      idle(2);
      rst_n = 1'b1;
      for (int w = 0; w < 6; w++) beat(DW'(32'h160 + w), 1'b0, (w == 3));
      idle(3);
      frame(32'h170, 3, 1'b1);
      idle(5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/line_buffer_nrow.md
Name: line_buffer_nrow

Overview:
- Parametrised N-row line buffer for the ISP window stage (demosaic, 3x3/5x5 filters); sits between the RAW/AXIS pixel stream and the matrix generator.
- Accepts one word per I_valid beat and outputs LINES vertically aligned taps per beat: current row plus LINES-1 previous rows.
- Adds over the single-row buffer: configurable row count and width, frame-sync state machine, tlast-checked line length, and selectable top-border handling (suppress or replicate).

Parameters:
- DATA_W, 33, bits per input word (packed pixels plus flags)
- LINES, 3, number of output taps (2..8); LINES-1 RAM lines are instantiated
- LINE_WORDS, 480, words per line (IMG_WIDTH/4 for 4-pixel packing); RAM depth
- ADDR_W, 11, address width; must satisfy 2^ADDR_W >= LINE_WORDS
- BORDER_MODE, 0, 0 = suppress output until primed; 1 = replicate oldest valid row into unfilled taps

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  asynchronous active-low reset
- I_tuser  in  1  start of frame, qualified by I_valid
- I_tlast  in  1  end of line, qualified by I_valid
- I_valid  in  1  input word valid
- I_data  in  DATA_W  input word
- O_valid  out  1  output taps valid
- O_data  out  LINES*DATA_W  taps; [DATA_W-1:0] = current row, tap k = k rows above
- O_tuser  out  1  first output word of frame
- O_tlast  out  1  last word of output line
- O_len_err  out  1  one-cycle pulse on line-length mismatch

Behaviour:
- Single clock: I_clk. Reset is asynchronous, active-low (I_rst_n); every register and output clears to 0 on reset. RAM contents are not reset.
- FSM states:
  - WAIT_SOF (reset state): input ignored until I_valid & I_tuser.
  - PRIME: entered on the SOF beat; held until LINES-1 lines have been written.
  - RUN: normal streaming.
- Any I_valid & I_tuser in any state restarts the frame at PRIME. That beat is word 0 of row 0 and is written at address 0 in the same pass.
- Word counter wcnt (ADDR_W bits) increments per I_valid beat. It wraps to 0 after LINE_WORDS-1 or on I_tlast. Row counter rcnt saturates at LINES-1; it increments on each wrap.
- Length check; either case pulses O_len_err 2 cycles after the beat:
  - I_tlast with wcnt != LINE_WORDS-1: counter restarts at 0, row counts as complete.
  - wcnt == LINE_WORDS-1 without I_tlast: counter wraps anyway.
- Pipeline, for an input beat at cycle t:
  - t: RAM k is read at wcnt.
  - t+1: read data returns aligned with registered input d0. RAM0 is written with d0 and RAM k with RAM(k-1) read data, both at the same address (read-before-write cascade).
  - t+2: registered O_data/O_valid/O_tuser/O_tlast.
  - Fixed latency: 2 cycles. Throughput: 1 word/cycle. No backpressure; idle cycles between beats are allowed and do not advance state.
- O_valid per mode:
  - BORDER_MODE=0: O_valid asserted only for beats in RUN, i.e. from row LINES-1 on.
  - BORDER_MODE=1: O_valid asserted for every beat after SOF. Tap k with k > rcnt outputs tap rcnt, so row 0 emits all taps = current row.
- O_tuser is set on the first output beat of a frame: beat (LINES-1,0) in mode 0, beat (0,0) in mode 1. O_tlast is set on the output of the beat where wcnt wrapped.
- End of frame: no flush. The last LINES-1 rows are not re-emitted, and the next SOF restarts priming.
- Reset mid-line: outputs drop within the asynchronous reset; the FSM returns to WAIT_SOF and the remainder of the frame is discarded.

Test Plan:
- LINES=3, LINE_WORDS=4, mode 0; SOF then rows of words 0x10+r*4+w, r=0..3 -> no O_valid for rows 0-1. Row 2 word 0 yields taps {0x10,0x14,0x18} (k2,k1,k0), 2 cycles after input. O_tuser on that beat, O_tlast on word 3.
- Same stream, mode 1 -> row 0 word 1 taps {0x11,0x11,0x11}; row 1 word 1 taps {0x11,0x11,0x15}; O_tuser on row 0 word 0.
- Random I_valid gaps (50% duty) -> output identical to back-to-back run and latency stays 2 cycles per beat.
- I_tlast on word 2 of row 1 -> O_len_err pulse. Row 2 begins at address 0 and the row counts as complete. Also no tlast at word 3 -> O_len_err, and the counter wraps.
- I_tuser mid-row 3 -> state PRIME, O_valid low for the next 2 rows (mode 0), new O_tuser at row 2 word 0 of the new frame.
- I_rst_n low mid-row, then release without I_tuser -> all outputs stay 0 and input is ignored until the next SOF beat.
